// File: rtl/output_evaluator_pkg.sv
// Shared types and helpers for the output evaluator: FSM encoding, index width,
// and bit offsets of the fields packed into the per-sample result word.
package output_evaluator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } eval_state_t;

    function automatic int calc_iw(input int no);
        return (no > 1) ? $clog2(no) : 1;
    endfunction

    // Result word is {hit, teacher_idx, pred_idx, pred_max}, MSB first.
    function automatic int res_width(input int iw, input int wo);
        return 1 + 2 * iw + wo;
    endfunction

    function automatic int off_pred_max();
        return 0;
    endfunction

    function automatic int off_pred_idx(input int wo);
        return wo;
    endfunction

    function automatic int off_teacher_idx(input int iw, input int wo);
        return wo + iw;
    endfunction

    function automatic int off_hit(input int iw, input int wo);
        return wo + 2 * iw;
    endfunction

endpackage

// File: rtl/output_evaluator_argmax_step.sv
// One step of a serial arg-max: keep the running {max, idx} unless the new
// element is strictly greater (signed), so ties stay at the lowest index.
module output_evaluator_argmax_step #(
    parameter int WO = 11,
    parameter int IW = 1
) (
    input  logic [WO-1:0] cur_max,
    input  logic [IW-1:0] cur_idx,
    input  logic [WO-1:0] elem,
    input  logic [IW-1:0] elem_idx,
    output logic [WO-1:0] new_max,
    output logic [IW-1:0] new_idx
);

    always_comb begin
        new_max = cur_max;
        new_idx = cur_idx;
        if ($signed(elem) > $signed(cur_max)) begin
            new_max = elem;
            new_idx = elem_idx;
        end
    end

endmodule

// File: rtl/output_evaluator.sv
// Joins output and teacher vectors, serially finds both arg-max indices and
// emits one hit/index/max result per sample while keeping accuracy counters.
//
//   state | meaning
//   IDLE  | waiting for both vectors; readies cross-coupled to the other valid
//   SCAN  | comparing element k of each latched vector against running max
//   EMIT  | result valid, held until iReady_BM_Result
module output_evaluator
    import output_evaluator_pkg::*;
#(
    parameter int NO = 2,
    parameter int WO = 11,
    parameter int CW = 16
) (
    input  logic                           iCLK,
    input  logic                           iRST,
    input  logic                           iClear,
    input  logic                           iValid_AM_Output,
    output logic                           oReady_AM_Output,
    input  logic [NO*WO-1:0]               iData_AM_Output,
    input  logic                           iValid_AM_Teacher,
    output logic                           oReady_AM_Teacher,
    input  logic [NO*WO-1:0]               iData_AM_Teacher,
    output logic                           oValid_BM_Result,
    input  logic                           iReady_BM_Result,
    output logic [1+2*calc_iw(NO)+WO-1:0]  oData_BM_Result,
    output logic [CW-1:0]                  oCorrect,
    output logic [CW-1:0]                  oTotal
);

    localparam int IW     = calc_iw(NO);
    localparam int RW     = res_width(IW, WO);
    localparam int O_MAX  = off_pred_max();
    localparam int O_PIDX = off_pred_idx(WO);
    localparam int O_TIDX = off_teacher_idx(IW, WO);
    localparam int O_HIT  = off_hit(IW, WO);

    eval_state_t state, state_nxt;

    logic [NO*WO-1:0] out_vec, tch_vec;
    logic [WO-1:0]    pred_max, tch_max;
    logic [IW-1:0]    pred_idx, tch_idx;
    logic [IW-1:0]    k;
    logic [WO-1:0]    out_elem, tch_elem;
    logic [WO-1:0]    pred_max_nxt, tch_max_nxt;
    logic [IW-1:0]    pred_idx_nxt, tch_idx_nxt;
    logic             accept, handshake, last_k, hit;
    logic [CW-1:0]    correct, total;

    assign last_k = (k == IW'(NO - 1));
    assign hit    = (pred_idx == tch_idx);

    always_comb begin
        out_elem = '0;
        tch_elem = '0;
        for (int i = 0; i < NO; i++) begin
            if (k == IW'(i)) begin
                out_elem = out_vec[i*WO +: WO];
                tch_elem = tch_vec[i*WO +: WO];
            end
        end
    end

    output_evaluator_argmax_step #(.WO(WO), .IW(IW)) u_step_out (
        .cur_max  (pred_max),
        .cur_idx  (pred_idx),
        .elem     (out_elem),
        .elem_idx (k),
        .new_max  (pred_max_nxt),
        .new_idx  (pred_idx_nxt)
    );

    output_evaluator_argmax_step #(.WO(WO), .IW(IW)) u_step_tch (
        .cur_max  (tch_max),
        .cur_idx  (tch_idx),
        .elem     (tch_elem),
        .elem_idx (k),
        .new_max  (tch_max_nxt),
        .new_idx  (tch_idx_nxt)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt         = state;
        oReady_AM_Output  = 1'b0;
        oReady_AM_Teacher = 1'b0;
        oValid_BM_Result  = 1'b0;
        accept            = 1'b0;
        handshake         = 1'b0;
        unique case (state)
            ST_IDLE: begin
                oReady_AM_Output  = iValid_AM_Teacher;
                oReady_AM_Teacher = iValid_AM_Output;
                accept            = iValid_AM_Output && iValid_AM_Teacher;
                if (accept) state_nxt = (NO > 1) ? ST_SCAN : ST_EMIT;
            end
            ST_SCAN: begin
                if (last_k) state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                oValid_BM_Result = 1'b1;
                handshake        = iReady_BM_Result;
                if (handshake) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            out_vec  <= '0;
            tch_vec  <= '0;
            pred_max <= '0;
            tch_max  <= '0;
            pred_idx <= '0;
            tch_idx  <= '0;
            k        <= '0;
        end else if (accept) begin
            out_vec  <= iData_AM_Output;
            tch_vec  <= iData_AM_Teacher;
            pred_max <= iData_AM_Output[WO-1:0];
            tch_max  <= iData_AM_Teacher[WO-1:0];
            pred_idx <= '0;
            tch_idx  <= '0;
            k        <= IW'(1);
        end else if (state == ST_SCAN) begin
            pred_max <= pred_max_nxt;
            tch_max  <= tch_max_nxt;
            pred_idx <= pred_idx_nxt;
            tch_idx  <= tch_idx_nxt;
            k        <= k + 1'b1;
        end
    end

    // Clear takes priority over a coincident handshake; counters stick at all-ones.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            correct <= '0;
            total   <= '0;
        end else if (iClear) begin
            correct <= '0;
            total   <= '0;
        end else if (handshake) begin
            if (total != '1)          total   <= total + 1'b1;
            if (hit && correct != '1) correct <= correct + 1'b1;
        end
    end

    always_comb begin
        oData_BM_Result = '0;
        if (oValid_BM_Result) begin
            oData_BM_Result[O_HIT]             = hit;
            oData_BM_Result[O_TIDX +: IW]      = tch_idx;
            oData_BM_Result[O_PIDX +: IW]      = pred_idx;
            oData_BM_Result[O_MAX +: WO]       = pred_max;
        end
    end

    assign oCorrect = correct;
    assign oTotal   = total;

    logic unused_ok;
    assign unused_ok = &{1'b0, tch_max_nxt[0], RW[0]};

endmodule

// File: tb/tb_output_evaluator.sv
// Randomized self-checking bench for output_evaluator against a plain arg-max
// reference model with saturating accuracy counters.
module tb_output_evaluator;

    localparam int NO = 4;
    localparam int WO = 11;
    localparam int CW = 4;
    localparam int IW = 2;
    localparam int RW = 1 + 2 * IW + WO;
    localparam int CMAX = (1 << CW) - 1;

    logic              clk, rst_n, clr;
    logic              v_out, v_tch, r_res;
    logic              rdy_out, rdy_tch, res_valid;
    logic [NO*WO-1:0]  d_out, d_tch;
    logic [RW-1:0]     res_data;
    logic [CW-1:0]     correct, total;

    int n_total, n_bad;
    int m_total, m_correct;
    int ov[NO];
    int tv[NO];

    output_evaluator #(.NO(NO), .WO(WO), .CW(CW)) dut (
        .iCLK              (clk),
        .iRST              (rst_n),
        .iClear            (clr),
        .iValid_AM_Output  (v_out),
        .oReady_AM_Output  (rdy_out),
        .iData_AM_Output   (d_out),
        .iValid_AM_Teacher (v_tch),
        .oReady_AM_Teacher (rdy_tch),
        .iData_AM_Teacher  (d_tch),
        .oValid_BM_Result  (res_valid),
        .iReady_BM_Result  (r_res),
        .oData_BM_Result   (res_data),
        .oCorrect          (correct),
        .oTotal            (total)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_total"}, 32'(total), 32'(m_total));
        check_eq({tag, "_correct"}, 32'(correct), 32'(m_correct));
    endtask

    // Reference: first strictly-greatest element wins.
    task automatic ref_argmax(input int v[NO], output int idx, output int mx);
        idx = 0;
        mx  = v[0];
        for (int i = 1; i < NO; i++) begin
            if (v[i] > mx) begin
                mx  = v[i];
                idx = i;
            end
        end
    endtask

    task automatic run_sample(input int bp, input bit clr_on_hs);
        int pi, pm, ti, tm, lat;
        bit hit;
        logic [RW-1:0] exp;
        logic [WO-1:0] pm_v;
        logic [IW-1:0] pi_v, ti_v;
        ref_argmax(ov, pi, pm);
        ref_argmax(tv, ti, tm);
        hit  = (pi == ti);
        pm_v = pm[WO-1:0];
        pi_v = pi[IW-1:0];
        ti_v = ti[IW-1:0];
        exp  = {hit, ti_v, pi_v, pm_v};
        for (int i = 0; i < NO; i++) begin
            d_out[i*WO +: WO] = ov[i][WO-1:0];
            d_tch[i*WO +: WO] = tv[i][WO-1:0];
        end
        v_out = 1'b1;
        v_tch = 1'b1;
        #1;
        check_eq("rdy_out_idle", 32'(rdy_out), 32'd1);
        check_eq("rdy_tch_idle", 32'(rdy_tch), 32'd1);
        tick();
        v_out = 1'b0;
        v_tch = 1'b0;
        d_out = '0;
        d_tch = '0;
        lat = 1;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(NO));
        for (int i = 0; i < bp; i++) begin
            check_eq("bp_valid", 32'(res_valid), 32'd1);
            check_eq("bp_data", 32'(res_data), 32'(exp));
            check_eq("bp_rdy", 32'({rdy_out, rdy_tch}), 32'd0);
            check_counters("bp");
            tick();
        end
        check_eq("result", 32'(res_data), 32'(exp));
        r_res = 1'b1;
        clr   = clr_on_hs;
        tick();
        r_res = 1'b0;
        clr   = 1'b0;
        if (clr_on_hs) begin
            m_total   = 0;
            m_correct = 0;
        end else begin
            if (m_total < CMAX) m_total++;
            if (hit && m_correct < CMAX) m_correct++;
        end
        check_eq("post_hs_valid", 32'(res_valid), 32'd0);
        check_counters("post_hs");
    endtask

    task automatic rand_vec(input bit narrow);
        for (int i = 0; i < NO; i++) begin
            if (narrow) begin
                ov[i] = int'($urandom_range(0, 6)) - 3;
                tv[i] = int'($urandom_range(0, 6)) - 3;
            end else begin
                ov[i] = int'($urandom_range(0, 2047)) - 1024;
                tv[i] = int'($urandom_range(0, 2047)) - 1024;
            end
        end
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        m_total = 0;
        m_correct = 0;
        rst_n = 1'b0;
        clr = 1'b0;
        v_out = 1'b0;
        v_tch = 1'b0;
        r_res = 1'b0;
        d_out = '0;
        d_tch = '0;
        #12;
        check_eq("rst_valid", 32'(res_valid), 32'd0);
        check_eq("rst_data", 32'(res_data), 32'd0);
        check_counters("rst");
        check_eq("rst_rdy", 32'({rdy_out, rdy_tch}), 32'd0);
        rst_n = 1'b1;
        tick();

        ov = '{5, -3, 9, 2};
        tv = '{0, 0, 256, 0};
        run_sample(0, 1'b0);

        ov = '{-7, -2, -2, -9};
        tv = '{0, 256, 0, 0};
        run_sample(0, 1'b0);

        ov = '{-1024, -1024, -1024, -1024};
        tv = '{0, 0, 0, 7};
        run_sample(2, 1'b0);

        // Teacher alone must not be consumed.
        v_tch = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("join_rdy_out", 32'(rdy_out), 32'd1);
            check_eq("join_rdy_tch", 32'(rdy_tch), 32'd0);
            check_eq("join_valid", 32'(res_valid), 32'd0);
            tick();
        end
        ov = '{1, 2, 3, 4};
        tv = '{4, 3, 2, 1};
        run_sample(6, 1'b0);

        for (int n = 0; n < 30; n++) begin
            rand_vec(n[0]);
            run_sample(int'($urandom_range(0, 3)), 1'b0);
        end

        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_total = 0;
        m_correct = 0;
        check_counters("idle_clear");

        for (int n = 0; n < 20; n++) begin
            rand_vec(1'b0);
            tv = ov;
            run_sample(0, 1'b0);
        end
        check_eq("sat_total", 32'(total), 32'(CMAX));
        check_eq("sat_correct", 32'(correct), 32'(CMAX));

        rand_vec(1'b0);
        run_sample(1, 1'b1);

        // Reset in the middle of a scan.
        ov = '{3, 8, 1, 0};
        tv = '{0, 9, 0, 0};
        for (int i = 0; i < NO; i++) begin
            d_out[i*WO +: WO] = ov[i][WO-1:0];
            d_tch[i*WO +: WO] = tv[i][WO-1:0];
        end
        v_out = 1'b1;
        v_tch = 1'b1;
        tick();
        v_out = 1'b0;
        v_tch = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        m_total = 0;
        m_correct = 0;
        check_eq("midrst_valid", 32'(res_valid), 32'd0);
        check_eq("midrst_data", 32'(res_data), 32'd0);
        check_counters("midrst");
        #3;
        rst_n = 1'b1;
        tick();
        run_sample(0, 1'b0);
        check_eq("after_rst_total", 32'(total), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
